// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: TileLink-UL opcodes, field widths and D response record.
package tl_ul_pkg;
  localparam int SRC_W  = 7;
  localparam int SIZE_W = 2;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0]        opcode;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
  } d_resp_t;
endpackage

// File: rtl/tl_resp_queue.sv
// tl_resp_queue: 2-entry in-order D response FIFO.
// Ports: clk, rst_n (async active-low), enq_valid/enq_ready/enq_data,
// deq_valid/deq_ready/deq_data (head held stable until dequeued).
module tl_resp_queue
  import tl_ul_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enq_valid,
  output logic    enq_ready,
  input  d_resp_t enq_data,
  output logic    deq_valid,
  input  logic    deq_ready,
  output d_resp_t deq_data
);
  logic [1:0] count;
  d_resp_t    e0, e1;
  logic       enq, deq;
  assign enq_ready = count != 2'd2;
  assign deq_valid = count != 2'd0;
  assign deq_data  = e0;
  assign enq       = enq_valid && enq_ready;
  assign deq       = deq_ready && deq_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      count <= count + 2'(enq) - 2'(deq);
      if (deq) e0 <= (count == 2'd2 || !enq) ? e1 : enq_data;
      else if (enq && count == 2'd0) e0 <= enq_data;
      // new entry lands behind the head when one entry remains after this edge
      if (enq && ((count == 2'd1 && !deq) || (count == 2'd2 && deq))) e1 <= enq_data;
    end
endmodule

// File: rtl/tl_ul_ram_slave.sv
// tl_ul_ram_slave: TileLink-UL single-beat RAM slave with 2-deep response queue.
// Ports: clock, reset (async active-low), auto_in_a_* request channel,
// auto_in_d_* response channel.
module tl_ul_ram_slave
  import tl_ul_pkg::*;
#(
  parameter int               DEPTH = 64,
  parameter logic [ADDR_W-1:0] BASE = 28'h0000000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [SIZE_W-1:0] auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [MASK_W-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0] auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [SIZE_W-1:0] auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic [DATA_W-1:0] auto_in_d_bits_data
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range, is_get, is_put, a_fire;
  d_resp_t           resp, head;
  logic              unused_bits;
  assign offset   = auto_in_a_bits_address - BASE;
  assign idx      = offset[IDX_W+2:3];
  assign in_range = auto_in_a_bits_address >= BASE && {3'b0, offset[ADDR_W-1:3]} < ADDR_W'(DEPTH);
  assign is_get   = auto_in_a_bits_opcode == A_GET;
  assign is_put   = auto_in_a_bits_opcode == A_PUT_FULL || auto_in_a_bits_opcode == A_PUT_PARTIAL;
  assign a_fire   = auto_in_a_valid && auto_in_a_ready;
  assign unused_bits = ^{auto_in_a_bits_param, offset[2:0]};
  always_comb begin
    resp.opcode = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    resp.size   = auto_in_a_bits_size;
    resp.source = auto_in_a_bits_source;
    resp.data   = (is_get && in_range) ? mem[idx] : '0;
  end
  always_ff @(posedge clock)
    if (a_fire && is_put && in_range && !auto_in_a_bits_corrupt)
      for (int i = 0; i < MASK_W; i++)
        if (auto_in_a_bits_mask[i]) mem[idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
  tl_resp_queue u_queue (
    .clk       (clock),
    .rst_n     (reset),
    .enq_valid (a_fire),
    .enq_ready (auto_in_a_ready),
    .enq_data  (resp),
    .deq_valid (auto_in_d_valid),
    .deq_ready (auto_in_d_ready),
    .deq_data  (head)
  );
  assign auto_in_d_bits_opcode = head.opcode;
  assign auto_in_d_bits_size   = head.size;
  assign auto_in_d_bits_source = head.source;
  assign auto_in_d_bits_data   = head.data;
endmodule

// File: tb/tb_tl_ul_ram_slave.sv
// tb_tl_ul_ram_slave: directed self-checking bench for tl_ul_ram_slave.
module tb_tl_ul_ram_slave;
  logic        clock = 0, reset = 0;
  logic        a_ready, a_valid = 0, a_corrupt = 0, d_ready = 0, d_valid;
  logic [2:0]  a_opcode = 0, a_param = 0, d_opcode;
  logic [1:0]  a_size = 0, d_size;
  logic [6:0]  a_source = 0, d_source;
  logic [27:0] a_address = 0;
  logic [7:0]  a_mask = 0;
  logic [63:0] a_data = 0, d_data;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  tl_ul_ram_slave dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
    .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
    .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_size(d_size),
    .auto_in_d_bits_source(d_source), .auto_in_d_bits_data(d_data)
  );

  task automatic a_send(input logic [2:0] op, input logic [6:0] src, input logic [27:0] addr,
                        input logic [7:0] mask, input logic [63:0] data, input logic corrupt);
    int n = 0;
    a_opcode = op; a_source = src; a_address = addr; a_mask = mask; a_data = data;
    a_corrupt = corrupt; a_size = 2'd3; a_param = 3'd5; a_valid = 1;
    while (!a_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (!a_ready) begin
      checks++; failures++;
      $display("FAIL a_send_timeout src=%0d a_ready=%b required 1", src, a_ready);
      a_valid = 0;
      return;
    end
    @(posedge clock); #1;
    a_valid = 0; a_corrupt = 0;
  endtask

  task automatic d_recv(input string name, input logic [2:0] op, input logic [6:0] src, input logic [63:0] data);
    int n = 0;
    d_ready = 1;
    while (!d_valid && n < 20) begin @(posedge clock); #1; n++; end
    checks++;
    if (d_valid !== 1'b1) begin
      failures++; $display("FAIL %s_timeout d_valid=%b required 1", name, d_valid);
      d_ready = 0; return;
    end
    checks++;
    if (d_opcode !== op || d_source !== src || d_size !== 2'd3) begin
      failures++;
      $display("FAIL %s_hdr opcode=%0d source=%0d size=%0d required opcode=%0d source=%0d size=3",
               name, d_opcode, d_source, d_size, op, src);
    end
    checks++;
    if (d_data !== data) begin
      failures++; $display("FAIL %s_data got=%h required=%h", name, d_data, data);
    end
    @(posedge clock); #1;
    d_ready = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_opcode !== 3'd0 || d_source !== 7'd0 || d_size !== 2'd0 || d_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_d valid=%b opcode=%0d source=%0d size=%0d data=%h required all 0",
               d_valid, d_opcode, d_source, d_size, d_data);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b required 1", a_ready); end
  endtask

  task automatic test_put_get;
    a_send(3'd0, 7'd10, 28'h08, 8'hFF, 64'h1122334455667788, 0);
    checks++;
    if (d_valid !== 1'b1) begin failures++; $display("FAIL latency_d_valid got=%b required 1", d_valid); end
    a_send(3'd4, 7'd11, 28'h08, 8'hFF, 64'h0, 0);
    d_recv("put_full_ack", 3'd0, 7'd10, 64'h0);
    d_recv("get_after_put", 3'd1, 7'd11, 64'h1122334455667788);
  endtask

  task automatic test_partial;
    a_send(3'd1, 7'd20, 28'h08, 8'h0F, 64'hFFFFFFFFAAAAAAAA, 0);
    a_send(3'd4, 7'd21, 28'h08, 8'h00, 64'h0, 0);
    d_recv("put_partial_ack", 3'd0, 7'd20, 64'h0);
    d_recv("get_partial", 3'd1, 7'd21, 64'h11223344AAAAAAAA);
  endtask

  task automatic test_back_to_back;
    logic [6:0] srcs [3];
    logic [63:0] held;
    logic [6:0] held_src;
    logic fire;
    int got = 0;
    a_send(3'd4, 7'd1, 28'h08, 8'hFF, 64'h0, 0);
    a_send(3'd4, 7'd2, 28'h08, 8'hFF, 64'h0, 0);
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL full_a_ready got=%b required 0", a_ready); end
    a_opcode = 3'd4; a_source = 7'd3; a_address = 28'h08; a_valid = 1;
    held = d_data; held_src = d_source;
    repeat (3) begin
      @(posedge clock); #1;
      checks++;
      if (d_data !== held || d_source !== held_src || d_valid !== 1'b1 || a_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_stable data=%h source=%0d valid=%b a_ready=%b required data=%h source=%0d valid=1 a_ready=0",
                 d_data, d_source, d_valid, a_ready, held, held_src);
      end
    end
    d_ready = 1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      fire = a_valid && a_ready;
      if (d_valid) begin
        srcs[got] = d_source;
        checks++;
        if (d_data !== 64'h11223344AAAAAAAA) begin
          failures++; $display("FAIL order_data beat=%0d got=%h required=11223344aaaaaaaa", got, d_data);
        end
        got++;
      end
      @(posedge clock); #1;
      if (fire) a_valid = 0;
    end
    d_ready = 0; a_valid = 0;
    checks++;
    if (got != 3 || srcs[0] !== 7'd1 || srcs[1] !== 7'd2 || srcs[2] !== 7'd3) begin
      failures++;
      $display("FAIL order_sources beats=%0d got=%0d,%0d,%0d required 3 beats 1,2,3", got, srcs[0], srcs[1], srcs[2]);
    end
  endtask

  task automatic test_out_of_range;
    a_send(3'd0, 7'd30, 28'h00, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0);
    d_recv("w0_ack", 3'd0, 7'd30, 64'h0);
    a_send(3'd4, 7'd31, 28'h200, 8'hFF, 64'h0, 0);
    d_recv("oor_get", 3'd1, 7'd31, 64'h0);
    a_send(3'd0, 7'd32, 28'h200, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 0);
    d_recv("oor_put", 3'd0, 7'd32, 64'h0);
    a_send(3'd4, 7'd33, 28'h00, 8'hFF, 64'h0, 0);
    d_recv("oor_w0_intact", 3'd1, 7'd33, 64'hA5A5A5A5A5A5A5A5);
  endtask

  task automatic test_unsupported;
    a_send(3'd2, 7'd40, 28'h00, 8'hFF, 64'h0123456789ABCDEF, 0);
    d_recv("arith_ack", 3'd0, 7'd40, 64'h0);
    a_send(3'd0, 7'd41, 28'h00, 8'hFF, 64'h5555555555555555, 1);
    d_recv("corrupt_ack", 3'd0, 7'd41, 64'h0);
    a_send(3'd4, 7'd42, 28'h00, 8'hFF, 64'h0, 0);
    d_recv("unsup_w0_intact", 3'd1, 7'd42, 64'hA5A5A5A5A5A5A5A5);
  endtask

  task automatic test_reset_mid;
    a_send(3'd4, 7'd50, 28'h00, 8'hFF, 64'h0, 0);
    a_send(3'd4, 7'd51, 28'h08, 8'hFF, 64'h0, 0);
    checks++;
    if (d_valid !== 1'b1 || a_ready !== 1'b0) begin
      failures++; $display("FAIL mid_queued d_valid=%b a_ready=%b required 1 0", d_valid, a_ready);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_data !== 64'd0 || d_source !== 7'd0) begin
      failures++; $display("FAIL mid_async_clear d_valid=%b data=%h source=%0d required 0", d_valid, d_data, d_source);
    end
    @(negedge clock) reset = 1;
    d_ready = 1;
    repeat (4) begin
      @(posedge clock); #1;
      checks++;
      if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
        failures++; $display("FAIL mid_no_stale d_valid=%b a_ready=%b required 0 1", d_valid, a_ready);
      end
    end
    d_ready = 0;
  endtask

  initial begin
    test_reset;
    test_put_get;
    test_partial;
    test_back_to_back;
    test_out_of_range;
    test_unsupported;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
